// File: rtl/sv_uart_tx_arbiter_if.sv
// Handshake bundle between the requester side and the engine side of the UART TX arbiter.
interface sv_uart_tx_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 24,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
);
    logic [NUM_REQ*DATA_WIDTH-1:0] s_axis_tdata;
    logic [NUM_REQ-1:0]            s_axis_tvalid;
    logic [NUM_REQ-1:0]            s_axis_tready;
    logic [DATA_WIDTH-1:0]         m_axis_tdata;
    logic                          m_axis_tvalid;
    logic                          m_axis_tready;
    logic [ID_WIDTH-1:0]           m_axis_tid;

    modport master (
        output s_axis_tdata, s_axis_tvalid, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tid
    );

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tid
    );
endinterface

// File: rtl/sv_uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART engine transmit channel between NUM_REQ
// AXI-stream requesters, with a programmable idle gap after each transmitted word.
module sv_uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 24,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                iclk,
    input  logic                irst_n,
    sv_uart_tx_arbiter_if.slave bus,
    input  logic [15:0]         igap,
    output logic                obusy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic [ID_WIDTH-1:0]     ptr_r;
    logic [15:0]             gap_cnt_r;
    logic [DATA_WIDTH-1:0]   m_tdata_r;
    logic                    m_tvalid_r;
    logic [ID_WIDTH-1:0]     m_tid_r;
    logic                    busy_r;

    logic                    win_found_s;
    logic [ID_WIDTH-1:0]     win_idx_s;
    logic [DATA_WIDTH-1:0]   win_data_s;
    logic [ID_WIDTH-1:0]     win_next_s;
    logic [NUM_REQ-1:0]      tready_s;

    assign bus.m_axis_tdata  = m_tdata_r;
    assign bus.m_axis_tvalid = m_tvalid_r;
    assign bus.m_axis_tid    = m_tid_r;
    assign bus.s_axis_tready = tready_s;
    assign obusy             = busy_r;

    // Winner search: first valid requester at or above the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        int idx;
        idx         = 0;
        win_found_s = 1'b0;
        win_idx_s   = '0;
        win_data_s  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr_r) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end else begin
                idx = idx;
            end
            if (!win_found_s && bus.s_axis_tvalid[idx]) begin
                win_found_s = 1'b1;
                win_idx_s   = ID_WIDTH'(idx);
                win_data_s  = bus.s_axis_tdata[idx*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                win_found_s = win_found_s;
            end
        end
        if (win_idx_s == ID_WIDTH'(NUM_REQ - 1)) begin
            win_next_s = '0;
        end else begin
            win_next_s = win_idx_s + ID_WIDTH'(1);
        end
    end

    // State register.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (win_found_s) begin
                    state_next_s = ST_SEND;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (bus.m_axis_tready) begin
                    if (igap == 16'd0) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_GAP;
                    end
                end else begin
                    state_next_s = ST_SEND;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == 16'd0) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_GAP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Requester ready decode; held low while reset is asserted so no grant can leak out.
    always_comb begin
        tready_s = '0;
        if (irst_n && (state_r == ST_IDLE) && win_found_s) begin
            tready_s[win_idx_s] = 1'b1;
        end else begin
            tready_s = '0;
        end
    end

    // Output word register, priority pointer, gap counter and busy flag.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            ptr_r      <= '0;
            gap_cnt_r  <= 16'd0;
            m_tdata_r  <= '0;
            m_tvalid_r <= 1'b0;
            m_tid_r    <= '0;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (win_found_s) begin
                        m_tdata_r  <= win_data_s;
                        m_tid_r    <= win_idx_s;
                        m_tvalid_r <= 1'b1;
                        ptr_r      <= win_next_s;
                    end
                end
                ST_SEND: begin
                    if (bus.m_axis_tready) begin
                        m_tvalid_r <= 1'b0;
                        // igap is captured only here; later changes do not stretch the gap.
                        if (igap != 16'd0) begin
                            gap_cnt_r <= igap - 16'd1;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r != 16'd0) begin
                        gap_cnt_r <= gap_cnt_r - 16'd1;
                    end
                end
                default: begin
                    m_tvalid_r <= 1'b0;
                end
            endcase
            busy_r <= (state_next_s != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_sv_uart_tx_arbiter.sv
// Scoreboard bench for the UART TX arbiter: grants are checked against a round-robin
// model, granted words are queued and compared when the engine side accepts them.
module tb_sv_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int DW = 24;

    logic            iclk;
    logic            irst_n;
    logic [15:0]     igap;
    logic            obusy;
    logic            m_ready;
    logic [NR-1:0]   req_valid;
    logic [DW-1:0]   req_word [NR];
    int              req_left [NR];
    int              req_seq  [NR];
    logic [NR*DW-1:0] tdata_pk;
    logic [NR-1:0]   hs_seen;

    int total_cnt;
    int bad_cnt;
    int pop_cnt;
    int cyc;
    int model_ptr;
    logic [DW+1:0] exp_q [$];
    int grant_log [$];
    int grant_cyc [$];

    logic          prev_v;
    logic          prev_r;
    logic [DW-1:0] prev_d;
    logic [1:0]    prev_id;

    sv_uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    sv_uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
        .iclk   (iclk),
        .irst_n (irst_n),
        .bus    (bus.slave),
        .igap   (igap),
        .obusy  (obusy)
    );

    always_comb begin
        tdata_pk = '0;
        for (int i = 0; i < NR; i++) tdata_pk[i*DW +: DW] = req_word[i];
    end
    assign bus.s_axis_tdata  = tdata_pk;
    assign bus.s_axis_tvalid = req_valid;
    assign bus.m_axis_tready = m_ready;

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    always @(posedge iclk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic refresh_valids();
        for (int i = 0; i < NR; i++) req_valid[i] = (req_left[i] != 0);
    endtask

    // Advance one clock; requesters that handshook on the last edge move to their next word.
    task automatic tick();
        @(posedge iclk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (hs_seen[i]) begin
                req_left[i] = req_left[i] - 1;
                req_seq[i]  = req_seq[i] + 1;
                req_word[i] = {8'(i), 16'(req_seq[i])};
            end
        end
        refresh_valids();
    endtask

    task automatic wait_drain(input int max_cyc);
        int n;
        logic pending;
        n = 0;
        pending = 1'b1;
        while (pending && n < max_cyc) begin
            pending = bus.m_axis_tvalid || obusy;
            for (int i = 0; i < NR; i++) if (req_left[i] != 0) pending = 1'b1;
            if (pending) begin
                tick();
                n++;
            end
        end
        check_eq("drain_timeout", 32'(pending), 32'd0);
    endtask

    task automatic pulse_reset();
        @(posedge iclk);
        #3 irst_n = 1'b0;
        @(negedge iclk);
        @(posedge iclk);
        #3 irst_n = 1'b1;
    endtask

    // Monitor: grant model, scoreboard push/pop, output stability while stalled.
    always @(negedge iclk) begin
        int w;
        int idx;
        logic [NR-1:0] exp_oh;
        logic [DW+1:0] ent;
        hs_seen = bus.s_axis_tready & req_valid;
        if (!irst_n) begin
            model_ptr = 0;
            exp_q.delete();
            prev_v = 1'b0;
            prev_r = 1'b0;
        end else begin
            check_eq("tready_onehot0", 32'($onehot0(bus.s_axis_tready)), 32'd1);
            if (prev_v && !prev_r) begin
                check_eq("hold_valid", 32'(bus.m_axis_tvalid), 32'd1);
                check_eq("hold_data", 32'(bus.m_axis_tdata), 32'(prev_d));
                check_eq("hold_tid", 32'(bus.m_axis_tid), 32'(prev_id));
            end
            if (bus.m_axis_tvalid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_word", 32'(bus.m_axis_tdata), 32'hFFFF_FFFF);
                end else begin
                    ent = exp_q.pop_front();
                    pop_cnt++;
                    check_eq("out_tid", 32'(bus.m_axis_tid), 32'(ent[DW+1:DW]));
                    check_eq("out_data", 32'(bus.m_axis_tdata), 32'(ent[DW-1:0]));
                end
            end
            if (bus.s_axis_tready != '0) begin
                w = -1;
                for (int i = 0; i < NR; i++) begin
                    idx = (model_ptr + i) % NR;
                    if (w < 0 && req_valid[idx]) w = idx;
                end
                exp_oh = (w >= 0) ? (NR'(1) << w) : '0;
                check_eq("grant_winner", 32'(bus.s_axis_tready), 32'(exp_oh));
                for (int i = 0; i < NR; i++) if (bus.s_axis_tready[i]) grant_log.push_back(i);
                grant_cyc.push_back(cyc);
                if (w >= 0) begin
                    exp_q.push_back({2'(w), req_word[w]});
                    model_ptr = (w + 1) % NR;
                end
            end
            prev_v  = bus.m_axis_tvalid;
            prev_r  = m_ready;
            prev_d  = bus.m_axis_tdata;
            prev_id = bus.m_axis_tid;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [DW-1:0] held;
        total_cnt = 0; bad_cnt = 0; pop_cnt = 0; cyc = 0; model_ptr = 0;
        prev_v = 1'b0; prev_r = 1'b0; prev_d = '0; prev_id = '0; hs_seen = '0;
        irst_n = 1'b0; igap = 16'd0; m_ready = 1'b0;
        for (int i = 0; i < NR; i++) begin
            req_left[i] = 0; req_seq[i] = 0; req_word[i] = {8'(i), 16'd0};
        end
        refresh_valids();

        // Reset state.
        repeat (2) @(posedge iclk);
        #3;
        check_eq("rst_mvalid", 32'(bus.m_axis_tvalid), 32'd0);
        check_eq("rst_mdata", 32'(bus.m_axis_tdata), 32'd0);
        check_eq("rst_mtid", 32'(bus.m_axis_tid), 32'd0);
        check_eq("rst_tready", 32'(bus.s_axis_tready), 32'd0);
        check_eq("rst_busy", 32'(obusy), 32'd0);
        irst_n = 1'b1;
        tick();

        // Single request from requester 2, igap=0.
        m_ready = 1'b1;
        req_word[2] = 24'hA1B2C3; req_left[2] = 1; refresh_valids();
        @(negedge iclk);
        check_eq("t1_tready", 32'(bus.s_axis_tready), 32'h4);
        tick();
        @(negedge iclk);
        check_eq("t1_mvalid", 32'(bus.m_axis_tvalid), 32'd1);
        check_eq("t1_mdata", 32'(bus.m_axis_tdata), 32'hA1B2C3);
        check_eq("t1_mtid", 32'(bus.m_axis_tid), 32'd2);
        check_eq("t1_busy", 32'(obusy), 32'd1);
        tick();
        @(negedge iclk);
        check_eq("t1_busy_low", 32'(obusy), 32'd0);
        check_eq("t1_mvalid_low", 32'(bus.m_axis_tvalid), 32'd0);
        wait_drain(20);

        // All four continuously valid from a fresh pointer.
        pulse_reset();
        base = grant_log.size();
        for (int i = 0; i < NR; i++) req_left[i] = 3;
        refresh_valids();
        wait_drain(100);
        for (int k = 0; k < 6; k++) check_eq("t2_order", 32'(grant_log[base+k]), 32'(k % 4));
        check_eq("t2_spacing", 32'(grant_cyc[base+1] - grant_cyc[base]), 32'd2);

        // Engine backpressure for 50 cycles with requesters 0 and 1 pending.
        m_ready = 1'b0;
        req_left[0] = 1; req_left[1] = 1; refresh_valids();
        @(negedge iclk);
        check_eq("t3_grant0", 32'(bus.s_axis_tready), 32'h1);
        held = req_word[0];
        tick();
        for (int k = 0; k < 50; k++) begin
            @(negedge iclk);
            check_eq("t3_stall_tready", 32'(bus.s_axis_tready), 32'd0);
            check_eq("t3_stall_data", 32'(bus.m_axis_tdata), 32'(held));
            tick();
        end
        m_ready = 1'b1;
        @(negedge iclk);
        tick();
        @(negedge iclk);
        check_eq("t3_grant1", 32'(bus.s_axis_tready), 32'h2);
        wait_drain(20);

        // igap=5 with requester 3 valid throughout; igap change mid-gap ignored.
        igap = 16'd5;
        req_left[3] = 2; refresh_valids();
        @(negedge iclk);
        check_eq("t4_grant", 32'(bus.s_axis_tready), 32'h8);
        tick();
        @(negedge iclk);
        check_eq("t4_send", 32'(bus.m_axis_tvalid), 32'd1);
        tick();
        for (int k = 1; k <= 5; k++) begin
            if (k == 2) igap = 16'd100;
            @(negedge iclk);
            check_eq("t4_gap_tready", 32'(bus.s_axis_tready), 32'd0);
            check_eq("t4_gap_busy", 32'(obusy), 32'd1);
            tick();
        end
        @(negedge iclk);
        check_eq("t4_regrant", 32'(bus.s_axis_tready), 32'h8);
        tick();
        igap = 16'd0;
        wait_drain(40);

        // Pointer wrap: move pointer to 3, then requesters 3 and 0 compete.
        req_left[2] = 1; refresh_valids();
        wait_drain(20);
        base = grant_log.size();
        req_left[3] = 2; req_left[0] = 2; refresh_valids();
        wait_drain(40);
        for (int k = 0; k < 4; k++)
            check_eq("t5_wrap", 32'(grant_log[base+k]), (k % 2 == 0) ? 32'd3 : 32'd0);

        // Asynchronous reset while a word is held in SEND.
        m_ready = 1'b0;
        req_left[2] = 1; refresh_valids();
        @(negedge iclk);
        tick();
        req_left[0] = 1; refresh_valids();
        #2 irst_n = 1'b0;
        #1;
        check_eq("t6_mvalid", 32'(bus.m_axis_tvalid), 32'd0);
        check_eq("t6_busy", 32'(obusy), 32'd0);
        check_eq("t6_tready", 32'(bus.s_axis_tready), 32'd0);
        @(negedge iclk);
        @(posedge iclk);
        #3 irst_n = 1'b1;
        m_ready = 1'b1;
        req_left[2] = 1; refresh_valids();
        @(negedge iclk);
        check_eq("t6_first", 32'(bus.s_axis_tready), 32'h1);
        wait_drain(20);

        repeat (3) tick();
        check_eq("final_queue", 32'(exp_q.size()), 32'd0);
        check_eq("final_pops", 32'(pop_cnt), 32'd24);
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/sv_uart_tx_arbiter.md
# sv_uart_tx_arbiter

Round-robin arbiter that shares one `sv_uart_engine` transmit channel between `NUM_REQ` AXI-stream requesters. It sits directly in front of the engine's `s_axis` port and accepts one `DATA_WIDTH` word per grant. Each accepted word is held in an output register until the engine accepts it. A programmable idle gap is then inserted before the next grant so that frames from different sources stay separated on the line.

## Interface

Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `DATA_WIDTH`, default 24: word width. Must equal the engine's `DATA_WIDTH`, be a multiple of 8, and be at least 8.
- `ID_WIDTH`, default `$clog2(NUM_REQ)`: width of the grant index. Derived; not to be overridden.

Ports:
- `iclk`  in  1  single clock.
- `irst_n`  in  1  reset, asynchronous assert, active-low.
- `s_axis_tdata`  in  `NUM_REQ*DATA_WIDTH`  requester words; requester i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `s_axis_tvalid`  in  `NUM_REQ`  per-requester valid.
- `s_axis_tready`  out  `NUM_REQ`  per-requester ready; at most one bit is high in any cycle.
- `m_axis_tdata`  out  `DATA_WIDTH`  word to the engine's `s_axis_tdata`.
- `m_axis_tvalid`  out  1  to the engine's `s_axis_tvalid`.
- `m_axis_tready`  in  1  from the engine's `s_axis_tready`.
- `m_axis_tid`  out  `ID_WIDTH`  index of the requester whose word is on `m_axis_tdata`.
- `igap`  in  16  idle cycles inserted after each engine handshake.
- `obusy`  out  1  high whenever the state is not IDLE.

## Operation

- FSM states: IDLE, SEND, GAP. Reset enters IDLE.
- Reset values:
  - `m_axis_tvalid=0`, `m_axis_tdata=0`, `m_axis_tid=0`, `s_axis_tready=0`, `obusy=0`.
  - Priority pointer = 0, so requester 0 has highest priority. Gap counter = 0.
- IDLE:
  - Winner = first requester with `tvalid=1`, searching upward from the pointer with wrap-around modulo `NUM_REQ`.
  - `s_axis_tready[winner]` is driven combinationally high only in IDLE, and only when at least one valid is present.
  - On the handshake: latch the winner's data into `m_axis_tdata` and the winner's index into `m_axis_tid`; set `m_axis_tvalid=1`; set the pointer to (winner+1) mod `NUM_REQ`; go to SEND.
  - With no valid requests: stay in IDLE; the pointer is unchanged.
- SEND:
  - `m_axis_tvalid` and `m_axis_tdata` are held stable until `m_axis_tready=1`. All `s_axis_tready` are 0.
  - On the handshake: clear `m_axis_tvalid`. If `igap==0`, go to IDLE. Otherwise load the counter with `igap-1` and go to GAP.
- GAP:
  - All `s_axis_tready` are 0.
  - The counter decrements once per cycle. Exit to IDLE in the cycle it reads 0.
  - `igap` is sampled only on the SEND→GAP transition. Changes during GAP have no effect.
- Requester valids that drop before being granted are never latched; no per-requester state is kept.
- A requester is never granted twice in a row while another requester is holding `tvalid` high.
- An asynchronous reset during SEND or GAP immediately clears `m_axis_tvalid` and discards the held word. The word is not retransmitted.

## Timing

- Grant latency: requester handshake in cycle N → `m_axis_tvalid=1` in cycle N+1.
- Gap spacing: engine handshake in cycle T → next requester handshake no earlier than cycle T+1+`igap`.
  - `igap=0`: one accepted word per two cycles when the engine's ready is held high.
- Width of `igap`: 16 bits, so the maximum gap is 65535 cycles with no overflow.
- All outputs are registered except `s_axis_tready`, which is decoded from state, pointer and `s_axis_tvalid`.
- `m_axis_tvalid` never deasserts without a handshake, except on reset.

## Test plan

- Single request, `igap=0`, engine ready held high: requester 2 presents 24'hA1B2C3 → `s_axis_tready[2]` high in cycle N; `m_axis_tdata=24'hA1B2C3` and `m_axis_tid=2` in N+1; handshake in N+1; `obusy` low in N+2.
- All four requesters valid continuously, engine ready high, `igap=0` → grant order 0,1,2,3,0,1; each word is accepted exactly once in sequence.
- Engine backpressure: `m_axis_tready` held low for 50 cycles while requesters 0 and 1 are valid → `m_axis_tdata` stable for all 50 cycles; no `s_axis_tready` asserted; requester 1 is granted in the cycle after the release.
- `igap=5`: handshake at T, requester 3 valid throughout → `s_axis_tready[3]` first high at T+6. Changing `igap` to 100 during GAP does not alter this.
- Pointer wrap: only requesters 3 and 0 valid, pointer at 3 → order 3,0,3,0.
- `irst_n` pulsed low mid-SEND (asynchronous, between clock edges) → `m_axis_tvalid`, `obusy` and `s_axis_tready` go to 0 immediately; after release, requester 0 wins first.
